dmem_responder: RTL
===================

# dmem_responder

Data-memory responder sitting on the far side of the CPU's M-stage data port: it accepts one load/store request at a time (address, byte-enables, write data), inserts wait states, and answers with an acknowledge plus read data. It stalls the pipeline through `busy` while a request is outstanding. It is the memory-side endpoint used in the SRAM functional-test SoC, backing a word-addressed on-chip array with byte-lane writes.

## Interface
- `ADDR_W`, 12, word-address width; the array holds 2^ADDR_W 32-bit words.
- `WAIT_CYCLES`, 2, wait states per access, 0..15; this is the fixed count, or the maximum when random waits are enabled.
- `LFSR_SEED`, 16'hACE1, reset value of the wait-state LFSR. Must be nonzero.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `req`  in  1  request valid (level); sampled only in IDLE.
- `wr`  in  1  1 = store, 0 = load.
- `be`  in  4  byte enables (CPU `sel`); bit i enables `wdata[8i+7:8i]`.
- `addr`  in  32  byte address (CPU ALU result).
- `wdata`  in  32  store data, already lane-aligned.
- `ack`  out  1  one-cycle response strobe.
- `rdata`  out  32  load data, valid with `ack`, held until next load `ack`.
- `err`  out  1  valid with `ack`; illegal `be` or out-of-range address.
- `busy`  out  1  stall request to hazard unit.

## Operation
- Physical address: phys = {3'b000, addr[28:0]}; word index = phys[ADDR_W+1:2].
- Range error: phys[31:ADDR_W+2] != 0.
- Legal `be` values: 0001, 0010, 0100, 1000, 0011, 1100, 1111. Any other value, including 0000, sets `err`.
- FSM states: IDLE, WAIT, RESP.
  - IDLE with req=1: latch wr/be/addr/wdata and the error flag; load the wait counter with N. Go to WAIT if N>0, else RESP.
  - WAIT: decrement the counter; go to RESP when counter==1.
  - RESP: assert `ack` for exactly one cycle, then return to IDLE.
- Reads: `rdata` is registered from the array at entry to RESP, so it is valid in the `ack` cycle.
- Reads with `err`=1 return 32'h0.
- Writes: enabled lanes of the latched word are written on the edge leaving RESP. No write occurs if `err`=1.
- `busy` is combinational: (state==IDLE && req) || state==WAIT. It is low during RESP so the CPU advances in the `ack` cycle.
- A request held high through RESP is not re-accepted. It is accepted on the next IDLE cycle as a new access.

## Timing
- Reset values: state IDLE, counter 0, `ack` 0, `err` 0, `rdata` 0, LFSR = LFSR_SEED. `busy` is 0 unless req=1 in IDLE. Array contents are not reset.
- Latency: req accepted at cycle 0 gives `ack` at cycle N+1.
- Throughput: one access per N+2 cycles with back-to-back requests.
- Read-after-write: the store commits at the end of its RESP cycle, before any later acceptance. A following load to the same word sees the new data; no bypass is needed.
- Reset mid-access (WAIT or RESP): the access is aborted, no write, no `ack`; the FSM returns to IDLE the next cycle.
- Inputs other than `req` are don't-care outside the IDLE acceptance cycle.

## Configuration
- `DMEM_RAND_WAIT_EN` defined: 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle.
  - At acceptance, N = lfsr[3:0] mod (WAIT_CYCLES+1).
  - The LFSR is deterministic from LFSR_SEED.
- Not defined: N = WAIT_CYCLES for every access; no LFSR logic is present.

## Structure
- Shared package `dmem_pkg`: FSM state enum (IDLE/WAIT/RESP), legal-`be` constant list, KSEG mask 32'h1FFF_FFFF, LFSR tap constant.
- One sub-module, `dmem_lfsr`: 16-bit LFSR with synchronous active-low reset to seed. It is instantiated only under `DMEM_RAND_WAIT_EN`.
- The array is inferred in the top level as per-lane byte writes.

## Test plan
- Store then load: WAIT_CYCLES=2. Store word 32'hDEADBEEF, be=1111 at addr 32'h8000_0010; then load the same address.
  - Each `ack` arrives 3 cycles after acceptance, with busy=1 for cycles 0–2.
  - The load returns rdata=32'hDEADBEEF, err=0.
- Byte and half stores: over word 32'h0, store be=0010 wdata=32'h0000AB00, then be=1100 wdata=32'h12340000. A load of the word returns 32'h1234AB00.
- Illegal enables and range: a store with be=0101 returns ack with err=1 and memory unchanged.
  - With ADDR_W=12, a load at addr 32'h0001_0000 returns err=1, rdata=0.
- Zero wait: with WAIT_CYCLES=0, req at cycle 0 gives ack at cycle 1 and busy high only in cycle 0.
  - With req held high, the next acceptance is at cycle 2.
- Reset mid-access: assert rst=0 during WAIT of a store to word 5.
  - Expected: no `ack`; word 5 keeps its old value; outputs at reset values the cycle after rst=0.
- Random waits (`DMEM_RAND_WAIT_EN`, WAIT_CYCLES=3): over 100 accesses, every latency is in 1..4, all four values occur, and the sequence is identical across two runs with the same seed.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM states, legal byte-enable
// patterns, KSEG address mask and the wait-state LFSR taps.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } stateT;

  localparam logic [31:0] KSEG_MASK = 32'h1FFF_FFFF;

  // Fibonacci taps 16,14,13,11 -> bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int unsigned NUM_LEGAL_BE = 7;
  localparam logic [NUM_LEGAL_BE*4-1:0] LEGAL_BE = {
    4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111
  };

  function automatic logic beLegal(input logic [3:0] be);
    logic ok;
    ok = 1'b0;
    for (int unsigned i = 0; i < NUM_LEGAL_BE; i++) begin
      if (LEGAL_BE[4*i +: 4] == be) ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/dmem_lfsr.sv
// 16-bit Fibonacci LFSR used to draw random wait-state counts; resets to SEED.
module dmem_lfsr
  import dmem_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] lfsr
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr <= SEED;
    end else begin
      lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, programmable wait states,
// byte-lane writes into a word array. Define DMEM_RAND_WAIT_EN for random waits.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned   ADDR_W      = 12,
  parameter int unsigned   WAIT_CYCLES = 2,
  parameter logic [15:0]   LFSR_SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [3:0]  be,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy
);

  stateT             state;
  logic [3:0]        cnt;
  logic              wrQ;
  logic [3:0]        beQ;
  logic [ADDR_W-1:0] idxQ;
  logic [31:0]       wdataQ;
  logic              errQ;

  logic [31:0]       mem [2**ADDR_W];

  logic [31:0]       phys;
  logic [ADDR_W-1:0] inIdx;
  logic              inErr;
  logic [3:0]        waitN;

  logic [ADDR_W-1:0] rdIdx;
  logic              rdErr;
  logic              rdLoad;
  logic              enterResp;
  logic              memWe;
  logic              unusedAddr;

  assign phys  = addr & KSEG_MASK;
  assign inIdx = phys[ADDR_W+1:2];
  assign inErr = !beLegal(be) || ((phys >> (ADDR_W + 2)) != '0);
  assign unusedAddr = ^addr[1:0];

`ifdef DMEM_RAND_WAIT_EN
  logic [15:0] lfsr;
  logic        unusedLfsr;

  dmem_lfsr #(.SEED(LFSR_SEED)) uLfsr (
    .clk  (clk),
    .rst  (rst),
    .lfsr (lfsr)
  );

  assign waitN      = 4'(32'(lfsr[3:0]) % (WAIT_CYCLES + 1));
  assign unusedLfsr = ^lfsr[15:4];
`else
  logic unusedSeed;

  assign waitN      = 4'(WAIT_CYCLES);
  assign unusedSeed = ^LFSR_SEED;
`endif

  assign busy = (state == IDLE && req) || state == WAIT;

  // Zero-wait accesses enter RESP straight from IDLE, so the read port must
  // look at the live request rather than the latched one in that case.
  always_comb begin
    rdIdx     = idxQ;
    rdErr     = errQ;
    rdLoad    = !wrQ;
    enterResp = 1'b0;
    if (state == IDLE) begin
      rdIdx     = inIdx;
      rdErr     = inErr;
      rdLoad    = !wr;
      enterResp = req && (waitN == '0);
    end else if (state == WAIT) begin
      enterResp = (cnt == 4'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      ack    <= 1'b0;
      err    <= 1'b0;
      rdata  <= '0;
      wrQ    <= 1'b0;
      beQ    <= '0;
      idxQ   <= '0;
      wdataQ <= '0;
      errQ   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            wrQ    <= wr;
            beQ    <= be;
            idxQ   <= inIdx;
            wdataQ <= wdata;
            errQ   <= inErr;
            cnt    <= waitN;
            state  <= (waitN != '0) ? WAIT : RESP;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      ack <= enterResp;
      err <= enterResp ? rdErr : 1'b0;
      if (enterResp && rdLoad) begin
        rdata <= rdErr ? '0 : mem[rdIdx];
      end
    end
  end

  // Store commits on the edge leaving RESP; a reset in RESP suppresses it.
  assign memWe = (state == RESP) && wrQ && !errQ && rst;

  always_ff @(posedge clk) begin
    if (memWe) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (beQ[i]) mem[idxQ][8*i +: 8] <= wdataQ[8*i +: 8];
      end
    end
  end

endmodule
